// File: rtl/bmu_req_arbiter.sv
// rtl/bmu_req_arbiter.sv - round-robin arbiter sharing one BMU between requesters
// Registered issue, ID tag pipeline for response routing, halt/drain FSM.
module bmu_req_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 32,
    parameter int BMU_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rstL,
    input  logic [NUM_REQ-1:0]          reqValid,
    output logic [NUM_REQ-1:0]          reqReady,
    input  logic [NUM_REQ*DATA_W-1:0]   reqA,
    input  logic [NUM_REQ*DATA_W-1:0]   reqB,
    input  logic [NUM_REQ*DATA_W-1:0]   reqOpcode,
    input  logic                        haltReq,
    output logic                        halted,
    output logic                        bmuValidIn,
    output logic [DATA_W-1:0]           bmuAIn,
    output logic [DATA_W-1:0]           bmuBIn,
    output logic [DATA_W-1:0]           bmuOpcode,
    input  logic [DATA_W-1:0]           bmuResultFf,
    input  logic                        bmuError,
    output logic [NUM_REQ-1:0]          rspValid,
    output logic [DATA_W-1:0]           rspData,
    output logic                        rspError,
    output logic [15:0]                 errCount
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    scan_id;
    logic               gnt_vld;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic [DATA_W-1:0]  sel_op;

    logic               bmu_valid_q;
    logic [ID_W-1:0]    bmu_id_q;
    logic [DATA_W-1:0]  bmu_a_q;
    logic [DATA_W-1:0]  bmu_b_q;
    logic [DATA_W-1:0]  bmu_op_q;

    logic               tag_vld_q [BMU_LATENCY];
    logic [ID_W-1:0]    tag_id_q  [BMU_LATENCY];
    logic               head_vld;
    logic [ID_W-1:0]    head_id;
    logic               pipe_busy;

    logic [15:0]        err_cnt_q;
    logic [15:0]        err_cnt_d;

    // Round-robin scan starting at the requester after the last one granted.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        scan_id = ptr_q;
        if (rstL && (state_q == ST_RUN) && !haltReq) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!gnt_vld && reqValid[scan_id]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = scan_id;
                end
                scan_id = (scan_id == ID_W'(NUM_REQ - 1)) ? '0 : scan_id + 1'b1;
            end
        end
    end

    assign reqReady = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;
    assign ptr_d    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                sel_a  = reqA[i*DATA_W +: DATA_W];
                sel_b  = reqB[i*DATA_W +: DATA_W];
                sel_op = reqOpcode[i*DATA_W +: DATA_W];
            end
        end
    end

    // Drain is complete once nothing will occupy the head stage after this edge;
    // an op currently at the head is delivered in this very cycle.
    always_comb begin
        pipe_busy = bmu_valid_q;
        for (int i = 0; i < BMU_LATENCY - 1; i++) begin
            pipe_busy = pipe_busy | tag_vld_q[i];
        end
    end

    assign head_vld = tag_vld_q[BMU_LATENCY-1];
    assign head_id  = tag_id_q[BMU_LATENCY-1];

    assign rspValid = head_vld ? (NUM_REQ'(1) << head_id) : '0;
    assign rspData  = head_vld ? bmuResultFf : '0;
    assign rspError = head_vld & bmuError;

    assign err_cnt_d = (head_vld && bmuError && (err_cnt_q != 16'hFFFF))
                     ? err_cnt_q + 16'd1 : err_cnt_q;

    always_ff @(posedge clk or negedge rstL) begin
        if (!rstL) begin
            state_q     <= ST_RUN;
            ptr_q       <= '0;
            bmu_valid_q <= 1'b0;
            bmu_id_q    <= '0;
            bmu_a_q     <= '0;
            bmu_b_q     <= '0;
            bmu_op_q    <= '0;
            err_cnt_q   <= '0;
            for (int i = 0; i < BMU_LATENCY; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_id_q[i]  <= '0;
            end
        end else begin
            bmu_valid_q <= gnt_vld;
            if (gnt_vld) begin
                ptr_q    <= ptr_d;
                bmu_id_q <= gnt_id;
                bmu_a_q  <= sel_a;
                bmu_b_q  <= sel_b;
                bmu_op_q <= sel_op;
            end
            tag_vld_q[0] <= bmu_valid_q;
            tag_id_q[0]  <= bmu_id_q;
            for (int i = 1; i < BMU_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            err_cnt_q <= err_cnt_d;
            case (state_q)
                ST_RUN:    if (haltReq)    state_q <= ST_DRAIN;
                ST_DRAIN:  if (!pipe_busy) state_q <= ST_HALTED;
                ST_HALTED: if (!haltReq)   state_q <= ST_RUN;
                default:                   state_q <= ST_RUN;
            endcase
        end
    end

    assign halted     = (state_q == ST_HALTED);
    assign bmuValidIn = bmu_valid_q;
    assign bmuAIn     = bmu_a_q;
    assign bmuBIn     = bmu_b_q;
    assign bmuOpcode  = bmu_op_q;
    assign errCount   = err_cnt_q;

endmodule

// File: doc/bmu_req_arbiter.md
Name: bmu_req_arbiter

Overview:
- Shares one BMU datapath between NUM_REQ requesters (for example the decode-issue path and the debug/CSR path).
- Arbitration is round-robin, one operation issued per cycle. The issue signals driven to the BMU are registered.
- Each issued op's requester ID is tracked through the BMU latency, so the result and error are routed back to the requester that issued it.
- A halt/drain FSM quiesces the BMU for flush or debug.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- DATA_W, 32: operand, opcode and result width.
- BMU_LATENCY, 1: cycles from bmuValidIn high to the matching bmuResultFf/bmuError being valid (1..4).

Ports:
- clk  input  1  clock
- rstL  input  1  asynchronous active-low reset
- reqValid  input  NUM_REQ  per-requester op request
- reqReady  output  NUM_REQ  per-requester grant; combinational, one-hot or zero
- reqA  input  NUM_REQ*DATA_W  operand A, slice i belongs to requester i
- reqB  input  NUM_REQ*DATA_W  operand B, slice i
- reqOpcode  input  NUM_REQ*DATA_W  opcode, slice i
- haltReq  input  1  stop issuing and drain the BMU
- halted  output  1  high when the BMU is empty and issue is stopped
- bmuValidIn  output  1  registered issue strobe to the BMU
- bmuAIn  output  DATA_W  registered operand A
- bmuBIn  output  DATA_W  registered operand B
- bmuOpcode  output  DATA_W  registered opcode
- bmuResultFf  input  DATA_W  BMU result
- bmuError  input  1  BMU error flag, valid alongside the result
- rspValid  output  NUM_REQ  one-cycle response pulse to requester i
- rspData  output  DATA_W  response result, valid with any rspValid bit
- rspError  output  1  response error, valid with any rspValid bit
- errCount  output  16  saturating count of error responses

Behaviour:
- **Reset (rstL low, async):**
  - All outputs go to 0.
  - FSM goes to RUN.
  - The RR pointer is set so requester 0 has highest priority.
  - The tag pipeline is cleared. In-flight ops are dropped: no rspValid is ever produced for them.
- **Arbitration (state RUN only):**
  - Grant the first requester with reqValid set, searching from (last granted + 1) mod NUM_REQ.
  - reqReady[i] = grant[i]; at most one bit is high.
  - reqReady is 0 in DRAIN and HALTED.
  - The pointer updates only when a handshake (reqValid & reqReady) occurs.
  - A requester must hold reqValid and its operands stable until reqReady is seen.
- **Issue timing:**
  - A handshake at edge t puts bmuValidIn=1 with that requester's A/B/opcode in cycle t+1.
  - With no handshake, bmuValidIn=0 and the data outputs hold their last values.
  - Back-to-back issue every cycle is supported.
- **Tag pipeline:**
  - BMU_LATENCY stages of {valid, id}, loaded alongside bmuValidIn.
  - When the head stage is valid: rspValid[id]=1, rspData=bmuResultFf, rspError=bmuError. This is combinational from the head stage and the BMU outputs, in cycle t+1+BMU_LATENCY.
  - Otherwise rspValid=0, rspData=0, rspError=0.
  - Responses have no backpressure. Responses come back in issue order.
- **errCount:** increments by 1 on each cycle with any rspValid bit set and rspError=1; saturates at 0xFFFF.
- **FSM:**
  - RUN: haltReq=1 goes to DRAIN. A grant is not given in the same cycle haltReq is seen.
  - DRAIN: the tag pipeline is empty and no issue is pending goes to HALTED.
  - HALTED: halted=1. haltReq=0 goes to RUN, and grants may resume in the next cycle.
  - DRAIN with haltReq dropped: finish draining, then go to HALTED, then to RUN. Never go directly from DRAIN to RUN.
- **Simultaneous events:**
  - A response and a new issue in the same cycle are both allowed.
  - If haltReq rises in the same cycle as a pending request, that request is not granted.

Test Plan:
- **Single op:** req0 with A=0x0000_00F0, B=0x0000_000F, BMU_LATENCY=1 -> bmuValidIn one cycle after the handshake; rspValid[0] pulse two cycles after the handshake with rspData=bmuResultFf; rspValid[1] stays 0.
- **Round-robin fairness:** req0 and req1 held high for 6 cycles -> grants 0,1,0,1,0,1; bmuValidIn high 6 consecutive cycles; responses come back in the same order with matching IDs.
- **Latency sweep:** BMU_LATENCY=3 with back-to-back ops from alternating requesters -> every response appears exactly 4 cycles after its handshake with the correct ID.
- **Halt and drain:** haltReq raised with 2 ops in flight -> reqReady=0 from that cycle; both responses are delivered; halted=1 one cycle after the last response; haltReq low -> the next grant occurs the following cycle.
- **Error counting:** 3 ops returning bmuError=1 -> rspError=1 on each response and errCount=3. Force 65540 errors -> errCount=0xFFFF.
- **Reset mid-operation:** rstL pulsed low with 2 ops in flight -> no rspValid after the release of reset; errCount=0; bmuValidIn=0; requester 0 wins the first post-reset contention.
